// File: rtl/instr_fetch_buffer_if.sv
// Purpose : bundles the instruction-ROM read port and the issue-side pair port
//           of instr_fetch_buffer.
// Modports: master - the fetch buffer (drives ROM request/address and the pair)
//           slave  - the environment (ROM data return and issue-side retire strobes)
// Signals : imem_req, imem_addr, imem_rdata              ROM read port
//           instruction0/1, valid0/1, take0/1             issue pair and retire
//           empty, count                                  drain status, occupancy
interface instr_fetch_buffer_if #(
  parameter int unsigned AW = 8,
  parameter int unsigned CW = 4
);
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_rdata;
  logic [31:0]   instruction0;
  logic [31:0]   instruction1;
  logic          valid0;
  logic          valid1;
  logic          take0;
  logic          take1;
  logic          empty;
  logic [CW-1:0] count;

  modport master (
    output imem_req, imem_addr, instruction0, instruction1, valid0, valid1, empty, count,
    input  imem_rdata, take0, take1
  );

  modport slave (
    input  imem_req, imem_addr, instruction0, instruction1, valid0, valid1, empty, count,
    output imem_rdata, take0, take1
  );
endinterface

// File: rtl/instr_fetch_buffer.sv
// Purpose : walks a word PC through a synchronous instruction ROM, buffers the
//           fetched words in a circular FIFO and presents the two oldest words
//           as an instruction pair; the issue side retires 0, 1 or 2 per en cycle.
// Ports   : clk, reset (sync, active-high), en (clock-enable strobe)
//           bus (master)  ROM request/address/data, instruction0/1, valid0/1,
//                         take0/1, empty, count
//           redirect, redirect_pc  only when FETCH_REDIRECT_EN is defined
// Config  : FETCH_REDIRECT_EN adds a PC redirect that flushes the FIFO.
module instr_fetch_buffer #(
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned IMEM_WORDS = 256,
  parameter int unsigned AW         = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
`ifdef FETCH_REDIRECT_EN
  input  logic                  redirect,
  input  logic [AW-1:0]         redirect_pc,
`endif
  instr_fetch_buffer_if.master  bus
);

  localparam int unsigned PW  = $clog2(DEPTH);
  localparam int unsigned CW  = PW + 1;
  // One extra bit so the PC can reach IMEM_WORDS and stop there.
  localparam int unsigned PCW = AW + 1;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t          state_q, state_n;
  logic [PCW-1:0]  pc_q;
  logic [PW-1:0]   rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]   count_q;
  logic            imem_req_q;
  logic [AW-1:0]   imem_addr_q;
  logic [31:0]     mem_q [DEPTH];

  logic            inflight_c, room_c, pc_ok_c, issue_c, push_c;
  logic            valid0_c, valid1_c;
  logic [1:0]      n_pop_c;
  logic            redir_c;
  logic [PCW-1:0]  redir_pc_c;

`ifdef FETCH_REDIRECT_EN
  assign redir_c    = redirect;
  assign redir_pc_c = PCW'(redirect_pc);
`else
  assign redir_c    = 1'b0;
  assign redir_pc_c = '0;
`endif

  assign valid0_c = (count_q != '0);
  assign valid1_c = (count_q >= CW'(2));

  // Fetch FSM next state plus push/pop/issue decisions for this en cycle.
  always_comb begin
    state_n    = state_q;
    issue_c    = 1'b0;
    push_c     = 1'b0;
    n_pop_c    = 2'd0;
    inflight_c = (state_q == WAIT);
    // Room check counts the in-flight word and ignores same-cycle pops.
    room_c     = (32'(count_q) + 32'(inflight_c)) < DEPTH;
    pc_ok_c    = 32'(pc_q) < IMEM_WORDS;

    if (bus.take0 && valid0_c) begin
      n_pop_c = (bus.take1 && valid1_c) ? 2'd2 : 2'd1;
    end

    case (state_q)
      IDLE: begin
        if (!pc_ok_c) begin
          state_n = DONE;
        end else if (room_c) begin
          issue_c = 1'b1;
          state_n = WAIT;
        end
      end
      WAIT: begin
        push_c = 1'b1;
        if (room_c && pc_ok_c) begin
          issue_c = 1'b1;
        end else begin
          state_n = IDLE;
        end
      end
      DONE:    state_n = DONE;
      default: state_n = IDLE;
    endcase

    // Redirect drops the in-flight word and overrides push and pop.
    if (redir_c) begin
      issue_c = 1'b0;
      push_c  = 1'b0;
      n_pop_c = 2'd0;
      state_n = (32'(redir_pc_c) < IMEM_WORDS) ? IDLE : DONE;
    end
  end

  // State, PC, pointers and ROM request registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      pc_q        <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      imem_req_q  <= 1'b0;
      imem_addr_q <= '0;
    end else if (en) begin
      state_q    <= state_n;
      imem_req_q <= issue_c;
      if (issue_c) begin
        imem_addr_q <= pc_q[AW-1:0];
        pc_q        <= pc_q + PCW'(1);
      end
      if (redir_c) begin
        pc_q     <= redir_pc_c;
        rd_ptr_q <= wr_ptr_q;
        count_q  <= '0;
      end else begin
        if (push_c) begin
          wr_ptr_q <= wr_ptr_q + PW'(1);
        end
        rd_ptr_q <= rd_ptr_q + PW'(n_pop_c);
        count_q  <= count_q + CW'(push_c) - CW'(n_pop_c);
      end
    end
  end

  // FIFO storage; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (!reset && en && push_c) begin
      mem_q[wr_ptr_q] <= bus.imem_rdata;
    end
  end

  assign bus.imem_req     = imem_req_q;
  assign bus.imem_addr    = imem_addr_q;
  assign bus.valid0       = valid0_c;
  assign bus.valid1       = valid1_c;
  assign bus.instruction0 = valid0_c ? mem_q[rd_ptr_q] : 32'h0;
  assign bus.instruction1 = valid1_c ? mem_q[rd_ptr_q + PW'(1)] : 32'h0;
  assign bus.count        = count_q;
  assign bus.empty        = (count_q == '0) && !inflight_c && (state_q == DONE);

endmodule

// File: tb/tb_instr_fetch_buffer.sv
// Purpose : directed self-checking bench for instr_fetch_buffer. Two instances:
//           u_dut (256-word ROM) and u_small (4-word ROM). ROM[i] = i+1.
module tb_instr_fetch_buffer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, en, reset_s, en_s;
`ifdef FETCH_REDIRECT_EN
  logic       redirect, redirect_s;
  logic [7:0] redirect_pc;
  logic [1:0] redirect_pc_s;
`endif

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  instr_fetch_buffer_if #(.AW(8), .CW(4)) bus_b ();
  instr_fetch_buffer_if #(.AW(2), .CW(4)) bus_s ();

  // Synchronous ROM model: the registered address is the ROM address register.
  assign bus_b.imem_rdata = 32'(bus_b.imem_addr) + 32'd1;
  assign bus_s.imem_rdata = 32'(bus_s.imem_addr) + 32'd1;

  instr_fetch_buffer #(.DEPTH(8), .IMEM_WORDS(256), .AW(8)) u_dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
`ifdef FETCH_REDIRECT_EN
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
`endif
    .bus         (bus_b)
  );

  instr_fetch_buffer #(.DEPTH(8), .IMEM_WORDS(4), .AW(2)) u_small (
    .clk         (clk),
    .reset       (reset_s),
    .en          (en_s),
`ifdef FETCH_REDIRECT_EN
    .redirect    (redirect_s),
    .redirect_pc (redirect_pc_s),
`endif
    .bus         (bus_s)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  initial begin
    reset = 1'b1; en = 1'b1; reset_s = 1'b1; en_s = 1'b1;
    bus_b.take0 = 1'b0; bus_b.take1 = 1'b0;
    bus_s.take0 = 1'b0; bus_s.take1 = 1'b0;
`ifdef FETCH_REDIRECT_EN
    redirect = 1'b0; redirect_pc = 8'h0; redirect_s = 1'b0; redirect_pc_s = 2'h0;
`endif
    tick(); tick();

    // Reset state
    check("rst_count",  32'(bus_b.count),  32'd0);
    check("rst_valid0", 32'(bus_b.valid0), 32'd0);
    check("rst_instr0", bus_b.instruction0, 32'h0);
    check("rst_empty",  32'(bus_b.empty),  32'd0);
    check("rst_req",    32'(bus_b.imem_req), 32'd0);
    check("rst_addr",   32'(bus_b.imem_addr), 32'd0);

    // 1: fill with no retirement
    reset = 1'b0;
    tick();
    check("t1_req_first",  32'(bus_b.imem_req),  32'd1);
    check("t1_addr_first", 32'(bus_b.imem_addr), 32'd0);
    check("t1_valid0_e1",  32'(bus_b.valid0),    32'd0);
    tick();
    check("t1_instr0_e2", bus_b.instruction0, 32'd1);
    check("t1_count_e2",  32'(bus_b.count),   32'd1);
    for (int k = 3; k <= 12; k++) begin
      tick();
      check("t1_fill_count", 32'(bus_b.count), (k - 1 > 8) ? 32'd8 : 32'(k - 1));
    end
    check("t1_instr0", bus_b.instruction0, 32'd1);
    check("t1_instr1", bus_b.instruction1, 32'd2);
    check("t1_valid1", 32'(bus_b.valid1),  32'd1);
    check("t1_addr_last", 32'(bus_b.imem_addr), 32'd7);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t1_no_req_full", 32'(bus_b.imem_req), 32'd0);
    end

    // 2: retire a pair from a full FIFO
    bus_b.take0 = 1'b1; bus_b.take1 = 1'b1;
    tick();
    bus_b.take0 = 1'b0; bus_b.take1 = 1'b0;
    check("t2_instr0", bus_b.instruction0, 32'd3);
    check("t2_instr1", bus_b.instruction1, 32'd4);
    check("t2_count",  32'(bus_b.count),   32'd6);
    check("t2_req_pop_cycle", 32'(bus_b.imem_req), 32'd0);
    tick();
    check("t2_refetch_req",  32'(bus_b.imem_req),  32'd1);
    check("t2_refetch_addr", 32'(bus_b.imem_addr), 32'd8);
    tick(); tick();
    check("t2_refill_count", 32'(bus_b.count),    32'd8);
    check("t2_refill_req",   32'(bus_b.imem_req), 32'd0);
    check("t2_instr0_kept",  bus_b.instruction0,  32'd3);

    // 3: take1 without take0 is ignored
    bus_b.take1 = 1'b1;
    tick();
    bus_b.take1 = 1'b0;
    check("t3_take1_only_count",  32'(bus_b.count),  32'd8);
    check("t3_take1_only_instr0", bus_b.instruction0, 32'd3);

    // 4: 4-word ROM drained with continuous take0; covers take0 at count==1
    reset_s = 1'b0;
    bus_s.take0 = 1'b1;
    tick();
    check("t4_req_first", 32'(bus_s.imem_req), 32'd1);
    for (int w = 1; w <= 4; w++) begin
      tick();
      check("t4_word",  bus_s.instruction0, 32'(w));
      check("t4_count", 32'(bus_s.count),   32'd1);
    end
    check("t4_empty_before_done", 32'(bus_s.empty), 32'd0);
    tick();
    check("t4_count_zero", 32'(bus_s.count),    32'd0);
    check("t4_valid0",     32'(bus_s.valid0),   32'd0);
    check("t4_instr0",     bus_s.instruction0,  32'h0);
    check("t4_empty",      32'(bus_s.empty),    32'd1);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t4_no_wrap_req", 32'(bus_s.imem_req), 32'd0);
      check("t4_still_empty", 32'(bus_s.empty),    32'd1);
    end
    bus_s.take0 = 1'b0;

    // 5: en strobed 1-in-4, then reset while a word is in flight
    reset = 1'b1; en = 1'b1;
    tick();
    reset = 1'b0;
    for (int s = 1; s <= 4; s++) begin
      en = 1'b1;
      tick();
      en = 1'b0;
      for (int g = 0; g < 4; g++) begin
        check("t5_count_stable", 32'(bus_b.count), 32'(s - 1));
        check("t5_req_held",     32'(bus_b.imem_req), 32'd1);
        check("t5_instr0_stable", bus_b.instruction0, (s >= 2) ? 32'd1 : 32'h0);
        check("t5_instr1_stable", bus_b.instruction1, (s >= 3) ? 32'd2 : 32'h0);
        if (g < 3) tick();
      end
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t5_rst_count",  32'(bus_b.count),     32'd0);
    check("t5_rst_req",    32'(bus_b.imem_req),  32'd0);
    check("t5_rst_valid0", 32'(bus_b.valid0),    32'd0);
    en = 1'b1;
    tick();
    check("t5_refetch_addr", 32'(bus_b.imem_addr), 32'd0);
    tick();
    check("t5_first_word", bus_b.instruction0, 32'd1);

`ifdef FETCH_REDIRECT_EN
    // 6: redirect with 5 words buffered
    tick(); tick(); tick(); tick();
    check("t6_pre_count", 32'(bus_b.count), 32'd5);
    redirect = 1'b1; redirect_pc = 8'h10;
    bus_b.take0 = 1'b1;
    tick();
    redirect = 1'b0;
    bus_b.take0 = 1'b0;
    check("t6_valid0_flushed", 32'(bus_b.valid0),   32'd0);
    check("t6_count_flushed",  32'(bus_b.count),    32'd0);
    check("t6_req_dropped",    32'(bus_b.imem_req), 32'd0);
    tick();
    check("t6_redirect_addr",  32'(bus_b.imem_addr), 32'h10);
    tick();
    check("t6_instr0", bus_b.instruction0, 32'd17);
    check("t6_count",  32'(bus_b.count),   32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
